asmi_arbiter: RTL

Shares the single ASMI serial-flash port (EPCS16) between two requesters: requester 0, the firmware-update writer (erase/program), and requester 1, a flash read-back/verify engine. Requesters get exclusive, whole-transaction ownership through round-robin arbitration. Ownership passes only once the flash reports not-busy, so an erase or page program is never cut off by the other requester. A watchdog flags a flash that stays busy too long.

---
 rtl/asmi_arbiter_if.sv | 56 +++++
 rtl/asmi_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/asmi_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | Module   : asmi_arbiter_if                                                 |
// | Purpose  : Bundle of requester-side and ASMI-side signals for the          |
// |            two-requester ASMI serial-flash arbiter.                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
// | Signals                                                                    |
// |   req[1:0]        request level, bit n = requester n                       |
// |   rel[1:0]        one-clock "transaction complete" pulse per requester     |
// |   rqN_addr[23:0]  flash byte address from requester N                      |
// |   rqN_ctrl[4:0]   {read, shift_bytes, write, sector_erase, wren}           |
// |   rqN_data[7:0]   data byte (already bit-reversed for ASMI)                |
// |   gnt[1:0]        one-hot registered grant                                 |
// |   asmi_*          muxed address/controls/data toward the ASMI block        |
// |   asmi_busy       busy flag from the ASMI megafunction                     |
// |   timeout         sticky busy watchdog flag                                |
// | Modports: master = requesters + flash side (stimulus), slave = arbiter.    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface asmi_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  rel;
  logic [23:0] rq0_addr;
  logic [23:0] rq1_addr;
  logic [4:0]  rq0_ctrl;
  logic [4:0]  rq1_ctrl;
  logic [7:0]  rq0_data;
  logic [7:0]  rq1_data;
  logic [1:0]  gnt;
  logic [23:0] asmi_addr;
  logic        asmi_wren;
  logic        asmi_sector_erase;
  logic        asmi_write;
  logic        asmi_shift_bytes;
  logic        asmi_read;
  logic [7:0]  asmi_datain;
  logic        asmi_busy;
  logic        timeout;

  modport master (
    output req, rel, rq0_addr, rq1_addr, rq0_ctrl, rq1_ctrl, rq0_data, rq1_data,
    output asmi_busy,
    input  gnt, asmi_addr, asmi_wren, asmi_sector_erase, asmi_write,
    input  asmi_shift_bytes, asmi_read, asmi_datain, timeout
  );

  modport slave (
    input  req, rel, rq0_addr, rq1_addr, rq0_ctrl, rq1_ctrl, rq0_data, rq1_data,
    input  asmi_busy,
    output gnt, asmi_addr, asmi_wren, asmi_sector_erase, asmi_write,
    output asmi_shift_bytes, asmi_read, asmi_datain, timeout
  );
endinterface

`default_nettype wire

// File: rtl/asmi_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : asmi_arbiter                                                    |
// | Purpose  : Round-robin, whole-transaction arbiter sharing one ASMI         |
// |            (EPCS16) port between a firmware-update writer (requester 0)   |
// |            and a read-back/verify engine (requester 1). Ownership only    |
// |            moves on once the flash reports not-busy; a watchdog flags a   |
// |            flash that stays busy too long.                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk   in   system clock, rising edge                                     |
// |   rst   in   asynchronous active-high reset                                |
// |   bus   slave modport of asmi_arbiter_if (requests, grant, ASMI mux)       |
// | Parameters                                                                 |
// |   BUSY_TIMEOUT  cycles allowed in DRAIN before timeout is flagged          |
// |   GAP           idle cycles between one grant ending and the next          |
// +----------------------------------------------------------------------------+
`default_nettype none

module asmi_arbiter #(
  parameter int BUSY_TIMEOUT = 25_000_000,
  parameter int GAP          = 2
) (
  input  logic          clk,
  input  logic          rst,
  asmi_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAPW  = 2'd3
  } state_t;

  localparam logic [24:0] C_TIMEOUT = 25'(BUSY_TIMEOUT);
  localparam logic [24:0] C_GAP     = 25'(GAP);

  state_t      r_state;
  logic [1:0]  r_gnt;
  logic        r_last;     // last winner; the other requester wins a tie
  logic [24:0] r_cnt;      // shared DRAIN watchdog / GAPW counter
  logic        r_timeout;

  state_t      w_state_nxt;
  logic [1:0]  w_gnt_nxt;
  logic        w_last_nxt;
  logic [24:0] w_cnt_nxt;
  logic        w_timeout_nxt;

  logic [24:0] w_cnt_inc;
  logic        w_pick1;
  logic        w_own_end;

  // Saturating increment: the counter never wraps back to zero.
  assign w_cnt_inc = (r_cnt == 25'h1FF_FFFF) ? r_cnt : r_cnt + 25'd1;

  assign w_pick1 = (bus.req == 2'b10) || ((bus.req == 2'b11) && !r_last);

  // Ownership ends on the owner's release pulse or when the owner drops req.
  // A release from the non-owner is masked off by r_gnt.
  assign w_own_end = ((bus.rel & r_gnt) != 2'b00) || ((bus.req & r_gnt) == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= 2'b00;
      r_last    <= 1'b1;
      r_cnt     <= 25'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = r_timeout;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 25'd0;
        if (!bus.asmi_busy && (bus.req != 2'b00)) begin
          w_state_nxt = ST_OWN;
          w_gnt_nxt   = w_pick1 ? 2'b10 : 2'b01;
          w_last_nxt  = w_pick1;
        end
      end
      ST_OWN: begin
        if (w_own_end) begin
          w_gnt_nxt   = 2'b00;
          w_cnt_nxt   = 25'd0;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!bus.asmi_busy) begin
          w_cnt_nxt   = 25'd0;
          w_state_nxt = ST_GAPW;
        end else if (w_cnt_inc >= C_TIMEOUT) begin
          // Give up waiting; IDLE still refuses to grant while busy is high.
          w_timeout_nxt = 1'b1;
          w_cnt_nxt     = 25'd0;
          w_state_nxt   = ST_GAPW;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_GAPW: begin
        if (w_cnt_inc >= C_GAP) begin
          w_cnt_nxt   = 25'd0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 2'b00;
        w_cnt_nxt   = 25'd0;
      end
    endcase
  end

  // Datapath mux keyed on the registered grant, so a non-owner's controls
  // can never leak through, and reset zeroes the outputs immediately.
  logic [23:0] w_addr;
  logic [4:0]  w_ctrl;
  logic [7:0]  w_data;

  always_comb begin
    w_addr = 24'd0;
    w_ctrl = 5'd0;
    w_data = 8'd0;
    case (r_gnt)
      2'b01: begin
        w_addr = bus.rq0_addr;
        w_ctrl = bus.rq0_ctrl;
        w_data = bus.rq0_data;
      end
      2'b10: begin
        w_addr = bus.rq1_addr;
        w_ctrl = bus.rq1_ctrl;
        w_data = bus.rq1_data;
      end
      default: begin
        w_addr = 24'd0;
        w_ctrl = 5'd0;
        w_data = 8'd0;
      end
    endcase
  end

  assign bus.gnt               = r_gnt;
  assign bus.timeout           = r_timeout;
  assign bus.asmi_addr         = w_addr;
  assign bus.asmi_read         = w_ctrl[4];
  assign bus.asmi_shift_bytes  = w_ctrl[3];
  assign bus.asmi_write        = w_ctrl[2];
  assign bus.asmi_sector_erase = w_ctrl[1];
  assign bus.asmi_wren         = w_ctrl[0];
  assign bus.asmi_datain       = w_data;

endmodule

`default_nettype wire
